// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, ACC mux codes and
// the halt state machine encoding.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_DM  = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_NOTIFY  = 2'd1,
        ST_WAIT_TX = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

endpackage

// File: rtl/bip_opcode_lut.sv
// Combinational opcode decoder: datapath enables, mux selects (with a flag
// saying whether the opcode assigns them), halt request and illegal flag.
module bip_opcode_lut
    import bip_pkg::*;
#(
    parameter int OPCODE_W      = 5,
    parameter bit ILLEGAL_HALTS = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                wrPc,
    output logic                wrAcc,
    output logic                wrRam,
    output logic                rdRam,
    output logic                setSelA,
    output logic [1:0]          selA,
    output logic                setSelB,
    output logic                selB,
    output logic                setOp,
    output logic                op,
    output logic                isHalt,
    output logic                illegal
);

    always_comb begin
        wrPc    = 1'b0;
        wrAcc   = 1'b0;
        wrRam   = 1'b0;
        rdRam   = 1'b0;
        setSelA = 1'b0;
        selA    = SEL_A_DM;
        setSelB = 1'b0;
        selB    = 1'b0;
        setOp   = 1'b0;
        op      = 1'b0;
        isHalt  = 1'b0;
        illegal = (opcode > OPCODE_W'(OP_SUBI));

        if (illegal) begin
            // An illegal opcode either stops the machine or is skipped like a NOP.
            wrPc   = ~ILLEGAL_HALTS;
            isHalt = ILLEGAL_HALTS;
        end else begin
            case (opcode[4:0])
                OP_HLT:  isHalt = 1'b1;
                OP_STO:  begin wrPc = 1'b1; wrRam = 1'b1; end
                OP_LD:   begin
                    wrPc = 1'b1; rdRam = 1'b1; wrAcc = 1'b1;
                    setSelA = 1'b1; selA = SEL_A_DM;
                end
                OP_LDI:  begin
                    wrPc = 1'b1; wrAcc = 1'b1;
                    setSelA = 1'b1; selA = SEL_A_IMM;
                end
                OP_ADD, OP_SUB: begin
                    wrPc = 1'b1; rdRam = 1'b1; wrAcc = 1'b1;
                    setSelA = 1'b1; selA = SEL_A_ALU;
                    setSelB = 1'b1; selB = 1'b1;
                    setOp = 1'b1; op = (opcode[4:0] == OP_ADD);
                end
                OP_ADDI, OP_SUBI: begin
                    wrPc = 1'b1; wrAcc = 1'b1;
                    setSelA = 1'b1; selA = SEL_A_ALU;
                    setSelB = 1'b1; selB = 1'b0;
                    setOp = 1'b1; op = (opcode[4:0] == OP_ADDI);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: registered opcode decode, halt/notify state machine and a
// saturating executed-instruction counter for the UART report.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int OPCODE_W      = 5,
    parameter int CNT_W         = 16,
    parameter bit ILLEGAL_HALTS = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_instr_valid,
    input  logic                i_tx_done,
    input  logic                i_resume,
    output logic                o_wr_pc,
    output logic [1:0]          o_sel_a,
    output logic                o_sel_b,
    output logic                o_wr_acc,
    output logic                o_op,
    output logic                o_wr_ram,
    output logic                o_rd_ram,
    output logic                o_tx_start,
    output logic                o_halted,
    output logic                o_illegal,
    output logic [CNT_W-1:0]    o_instr_count
);

    state_t             stateReg, stateNext;
    logic               accept;
    logic               lutWrPc, lutWrAcc, lutWrRam, lutRdRam;
    logic               lutSetSelA, lutSetSelB, lutSetOp;
    logic [1:0]         lutSelA;
    logic               lutSelB, lutOp, lutIsHalt, lutIllegal;
    logic               wrPcReg, wrAccReg, wrRamReg, rdRamReg;
    logic [1:0]         selAReg;
    logic               selBReg, opReg, illegalReg;
    logic [CNT_W-1:0]   countReg;
    logic               txStart, halted;

    // Instructions are only taken while running; everything else ignores valid.
    assign accept = (stateReg == ST_RUN) && i_instr_valid;

    bip_opcode_lut #(
        .OPCODE_W      (OPCODE_W),
        .ILLEGAL_HALTS (ILLEGAL_HALTS)
    ) u_lut (
        .opcode  (i_opcode),
        .wrPc    (lutWrPc),
        .wrAcc   (lutWrAcc),
        .wrRam   (lutWrRam),
        .rdRam   (lutRdRam),
        .setSelA (lutSetSelA),
        .selA    (lutSelA),
        .setSelB (lutSetSelB),
        .selB    (lutSelB),
        .setOp   (lutSetOp),
        .op      (lutOp),
        .isHalt  (lutIsHalt),
        .illegal (lutIllegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= ST_RUN;
            wrPcReg    <= 1'b0;
            wrAccReg   <= 1'b0;
            wrRamReg   <= 1'b0;
            rdRamReg   <= 1'b0;
            selAReg    <= SEL_A_DM;
            selBReg    <= 1'b0;
            opReg      <= 1'b0;
            illegalReg <= 1'b0;
            countReg   <= '0;
        end else begin
            stateReg <= stateNext;
            wrPcReg  <= accept & lutWrPc;
            wrAccReg <= accept & lutWrAcc;
            wrRamReg <= accept & lutWrRam;
            rdRamReg <= accept & lutRdRam;
            if (accept && lutSetSelA) selAReg <= lutSelA;
            if (accept && lutSetSelB) selBReg <= lutSelB;
            if (accept && lutSetOp)   opReg   <= lutOp;
            if (accept && lutIllegal) illegalReg <= 1'b1;
            if (accept && (countReg != {CNT_W{1'b1}}))
                countReg <= countReg + CNT_W'(1);
        end
    end

    always_comb begin
        stateNext = stateReg;
        txStart   = 1'b0;
        halted    = 1'b1;
        case (stateReg)
            ST_RUN: begin
                halted = 1'b0;
                if (accept && lutIsHalt) stateNext = ST_NOTIFY;
            end
            // A tx_done arriving here is deliberately dropped.
            ST_NOTIFY: begin
                txStart   = 1'b1;
                stateNext = ST_WAIT_TX;
            end
            ST_WAIT_TX: if (i_tx_done) stateNext = ST_HALTED;
            ST_HALTED:  if (i_resume)  stateNext = ST_RUN;
            default:    stateNext = ST_RUN;
        endcase
    end

    assign o_wr_pc       = wrPcReg;
    assign o_wr_acc      = wrAccReg;
    assign o_wr_ram      = wrRamReg;
    assign o_rd_ram      = rdRamReg;
    assign o_sel_a       = selAReg;
    assign o_sel_b       = selBReg;
    assign o_op          = opReg;
    assign o_illegal     = illegalReg;
    assign o_instr_count = countReg;
    assign o_tx_start    = txStart;
    assign o_halted      = halted;

endmodule
